// File: rtl/mhb_pkg.sv
// Shared register map, CONTROL/STATUS/EVENT bit positions and load FSM states
// for the multi-core host bridge.
package mhb_pkg;

  localparam logic [7:0] REG_CONTROL    = 8'h00;
  localparam logic [7:0] REG_STATUS     = 8'h04;
  localparam logic [7:0] REG_PROG_DATA  = 8'h08;
  localparam logic [7:0] REG_FIFO_COUNT = 8'h0C;
  localparam logic [7:0] REG_EVENT      = 8'h10;
  localparam logic [7:0] REG_LAST_LEN   = 8'h14;
  localparam logic [7:0] REG_CORE_RESET = 8'h18;

  localparam int CTRL_LOAD      = 0;
  localparam int CTRL_START     = 1;
  localparam int CTRL_IRQ_EN    = 3;
  localparam int CTRL_CH_SEL_LO = 8;

  localparam int STAT_EMPTY = 0;
  localparam int STAT_FULL  = 1;
  localparam int STAT_BUSY  = 2;
  localparam int DONE_LO    = 8;

  localparam int EV_LOAD_DONE = 0;
  localparam int EV_OVERFLOW  = 1;
  localparam int EV_CMD_ERROR = 2;
  localparam int EV_ABORT     = 3;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    STREAM = 2'd1,
    FINISH = 2'd2
  } state_e;

endpackage

// File: rtl/mhb_prog_fifo.sv
// Program word FIFO: head is visible combinationally so the stream interface
// can present it the same cycle; flush has priority over push and pop.
module mhb_prog_fifo #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 256
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      push,
  input  logic [DATA_W-1:0]         push_data,
  input  logic                      pop,
  input  logic                      flush,
  output logic [DATA_W-1:0]         head,
  output logic [$clog2(DEPTH):0]    count,
  output logic                      full,
  output logic                      empty
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW-1:0]     wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]     count_q, count_d;
  logic              push_ok, pop_ok;

  assign full  = (count_q == CW'(DEPTH));
  assign empty = (count_q == '0);
  assign count = count_q;
  assign head  = mem[rd_ptr_q];

  // A push at full is accepted only when the head leaves in the same cycle.
  assign push_ok = push && (!full || pop) && !flush;
  assign pop_ok  = pop && !empty && !flush;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push_ok) wr_ptr_d = wr_ptr_q + AW'(1);
      if (pop_ok)  rd_ptr_d = rd_ptr_q + AW'(1);
      case ({push_ok, pop_ok})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr_q] <= push_data;
  end

endmodule

// File: rtl/multi_core_host_bridge.sv
// HPS-facing register block that queues program words, streams them to one
// selected core, issues start pulses and collects done/event flags into an irq.
module multi_core_host_bridge
  import mhb_pkg::*;
#(
  parameter int DATA_W     = 32,
  parameter int NUM_CH     = 4,
  parameter int BUF_DEPTH  = 256,
  parameter int NUM_STATUS = 16
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [7:0]                   hps_address,
  input  logic                         hps_write,
  input  logic                         hps_read,
  input  logic [DATA_W-1:0]            hps_writedata,
  output logic [DATA_W-1:0]            hps_readdata,
  output logic                         hps_readdatavalid,
  output logic                         hps_waitrequest,
  output logic [DATA_W-1:0]            prog_data,
  output logic [NUM_CH-1:0]            prog_valid,
  input  logic [NUM_CH-1:0]            prog_ready,
  output logic                         prog_last,
  output logic [NUM_CH-1:0]            start_exec,
  input  logic [NUM_CH-1:0]            exec_done,
  output logic [NUM_CH-1:0]            core_reset,
  input  logic [NUM_STATUS*DATA_W-1:0] status_data,
  output logic                         irq
);
  localparam int CW = $clog2(BUF_DEPTH) + 1;

  state_e              state_q, state_d;
  logic [2:0]          ch_q, ch_d, ch_sel_q, ch_sel_d, sel_w;
  logic [CW-1:0]       remaining_q, remaining_d, len_q, len_d, last_len_q, last_len_d;
  logic                irq_en_q, irq_en_d, irq_q, irq_d;
  logic [NUM_CH-1:0]   core_reset_q, core_reset_d, done_q, done_d;
  logic [NUM_CH-1:0]   start_exec_q, start_exec_d, exec_prev_q, exec_prev_d;
  logic                ev_load_done_q, ev_load_done_d, ev_overflow_q, ev_overflow_d;
  logic                ev_cmd_error_q, ev_cmd_error_d, ev_abort_q, ev_abort_d;
  logic [DATA_W-1:0]   readdata_q, readdata_d, rdata, ev_clr;
  logic                readdatavalid_q, readdatavalid_d;
  logic [DATA_W-1:0]   status_words [NUM_STATUS];

  logic [DATA_W-1:0]   fifo_head;
  logic [CW-1:0]       fifo_count;
  logic                fifo_full, fifo_empty;
  logic                wr_ctrl, wr_prog, wr_event, wr_core_reset;
  logic                streaming, abort, fire, sel_valid, cmd_err_set, load_done_set;
  logic [NUM_CH-1:0]   ch_oh, sel_oh, done_clr;

  for (genvar gi = 0; gi < NUM_STATUS; gi++) begin : g_status
    assign status_words[gi] = status_data[gi*DATA_W +: DATA_W];
  end

  assign wr_ctrl       = hps_write && (hps_address == REG_CONTROL);
  assign wr_prog       = hps_write && (hps_address == REG_PROG_DATA);
  assign wr_event      = hps_write && (hps_address == REG_EVENT);
  assign wr_core_reset = hps_write && (hps_address == REG_CORE_RESET);
  assign sel_w         = hps_writedata[CTRL_CH_SEL_LO +: 3];
  assign sel_valid     = int'(sel_w) < NUM_CH;
  assign sel_oh        = NUM_CH'(1) << sel_w;
  assign ch_oh         = NUM_CH'(1) << ch_q;
  assign streaming     = (state_q == STREAM);

  // Holding the streaming core in reset (already, or by this write) kills the load.
  assign abort = streaming && ((|(core_reset_q & ch_oh)) ||
                               (wr_core_reset && |(hps_writedata[NUM_CH-1:0] & ch_oh)));
  assign fire  = streaming && |(prog_ready & ch_oh) && !abort;

  mhb_prog_fifo #(.DATA_W(DATA_W), .DEPTH(BUF_DEPTH)) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (wr_prog),
    .push_data (hps_writedata),
    .pop       (fire),
    .flush     (abort),
    .head      (fifo_head),
    .count     (fifo_count),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  always_comb begin
    rdata = '0;
    case (hps_address)
      REG_CONTROL: begin
        rdata[CTRL_IRQ_EN]         = irq_en_q;
        rdata[CTRL_CH_SEL_LO +: 3] = ch_sel_q;
      end
      REG_STATUS: begin
        rdata[STAT_EMPTY]    = fifo_empty;
        rdata[STAT_FULL]     = fifo_full;
        rdata[STAT_BUSY]     = (state_q != IDLE);
        rdata[DONE_LO +: 8]  = 8'(done_q);
      end
      REG_FIFO_COUNT: rdata[CW-1:0] = fifo_count;
      REG_EVENT: begin
        rdata[EV_LOAD_DONE] = ev_load_done_q;
        rdata[EV_OVERFLOW]  = ev_overflow_q;
        rdata[EV_CMD_ERROR] = ev_cmd_error_q;
        rdata[EV_ABORT]     = ev_abort_q;
        rdata[DONE_LO +: 8] = 8'(done_q);
      end
      REG_LAST_LEN:   rdata[CW-1:0]     = last_len_q;
      REG_CORE_RESET: rdata[NUM_CH-1:0] = core_reset_q;
      default: begin
        if (hps_address[7:6] == 2'b01 && hps_address[1:0] == 2'b00 &&
            int'(hps_address[5:2]) < NUM_STATUS)
          rdata = status_words[hps_address[5:2]];
      end
    endcase
  end

  always_comb begin
    state_d         = state_q;
    ch_d            = ch_q;
    remaining_d     = remaining_q;
    len_d           = len_q;
    last_len_d      = last_len_q;
    irq_en_d        = irq_en_q;
    ch_sel_d        = ch_sel_q;
    core_reset_d    = core_reset_q;
    start_exec_d    = '0;
    exec_prev_d     = exec_done;
    cmd_err_set     = 1'b0;
    load_done_set   = 1'b0;
    done_clr        = '0;
    ev_clr          = wr_event ? hps_writedata : '0;

    if (wr_ctrl) begin
      irq_en_d = hps_writedata[CTRL_IRQ_EN];
      ch_sel_d = sel_w;
      if (hps_writedata[CTRL_LOAD]) begin
        if (state_q != IDLE || !sel_valid) begin
          cmd_err_set = 1'b1;
        end else if (!fifo_empty) begin
          ch_d        = sel_w;
          remaining_d = fifo_count;
          len_d       = fifo_count;
          state_d     = STREAM;
        end
      end
      if (hps_writedata[CTRL_START]) begin
        if (sel_valid) begin
          start_exec_d = sel_oh;
          done_clr     = sel_oh;
        end else begin
          cmd_err_set = 1'b1;
        end
      end
    end
    if (wr_core_reset) core_reset_d = hps_writedata[NUM_CH-1:0];

    case (state_q)
      STREAM: begin
        if (abort) begin
          state_d = IDLE;
        end else if (fire) begin
          remaining_d = remaining_q - CW'(1);
          if (remaining_q == CW'(1)) state_d = FINISH;
        end
      end
      FINISH: begin
        last_len_d    = len_q;
        load_done_set = 1'b1;
        state_d       = IDLE;
      end
      default: ;
    endcase

    // Set wins over a same-cycle write-1-to-clear.
    ev_load_done_d = (ev_load_done_q & ~ev_clr[EV_LOAD_DONE]) | load_done_set;
    ev_overflow_d  = (ev_overflow_q & ~ev_clr[EV_OVERFLOW]) | (wr_prog && fifo_full && !fire);
    ev_cmd_error_d = (ev_cmd_error_q & ~ev_clr[EV_CMD_ERROR]) | cmd_err_set;
    ev_abort_d     = (ev_abort_q & ~ev_clr[EV_ABORT]) | abort;
    done_d         = (done_q & ~(ev_clr[DONE_LO +: NUM_CH] | done_clr)) | (exec_done & ~exec_prev_q);
    irq_d          = irq_en_d & (ev_load_done_d | ev_overflow_d | ev_cmd_error_d |
                                 ev_abort_d | (|done_d));
    readdata_d      = hps_read ? rdata : '0;
    readdatavalid_d = hps_read;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q         <= IDLE;
      ch_q            <= '0;
      remaining_q     <= '0;
      len_q           <= '0;
      last_len_q      <= '0;
      irq_en_q        <= 1'b0;
      ch_sel_q        <= '0;
      core_reset_q    <= '0;
      done_q          <= '0;
      start_exec_q    <= '0;
      exec_prev_q     <= '0;
      ev_load_done_q  <= 1'b0;
      ev_overflow_q   <= 1'b0;
      ev_cmd_error_q  <= 1'b0;
      ev_abort_q      <= 1'b0;
      irq_q           <= 1'b0;
      readdata_q      <= '0;
      readdatavalid_q <= 1'b0;
    end else begin
      state_q         <= state_d;
      ch_q            <= ch_d;
      remaining_q     <= remaining_d;
      len_q           <= len_d;
      last_len_q      <= last_len_d;
      irq_en_q        <= irq_en_d;
      ch_sel_q        <= ch_sel_d;
      core_reset_q    <= core_reset_d;
      done_q          <= done_d;
      start_exec_q    <= start_exec_d;
      exec_prev_q     <= exec_prev_d;
      ev_load_done_q  <= ev_load_done_d;
      ev_overflow_q   <= ev_overflow_d;
      ev_cmd_error_q  <= ev_cmd_error_d;
      ev_abort_q      <= ev_abort_d;
      irq_q           <= irq_d;
      readdata_q      <= readdata_d;
      readdatavalid_q <= readdatavalid_d;
    end
  end

  assign hps_readdata      = readdata_q;
  assign hps_readdatavalid = readdatavalid_q;
  assign hps_waitrequest   = 1'b0;
  assign prog_valid        = streaming ? ch_oh : '0;
  assign prog_data         = streaming ? fifo_head : '0;
  assign prog_last         = streaming && (remaining_q == CW'(1));
  assign start_exec        = start_exec_q;
  assign core_reset        = core_reset_q;
  assign irq               = irq_q;

endmodule

// File: tb/tb_multi_core_host_bridge.sv
// Directed bench: register vector table plus hand sequences for load streaming,
// overflow, back-pressure, abort, reset mid-stream and start/done handling.
module tb_multi_core_host_bridge;
  localparam int NS = 16;

  logic          clk = 1'b0;
  logic          reset;
  logic [7:0]    hps_address;
  logic          hps_write, hps_read;
  logic [31:0]   hps_writedata, hps_readdata;
  logic          hps_readdatavalid, hps_waitrequest;
  logic [31:0]   prog_data;
  logic [3:0]    prog_valid, prog_ready, start_exec, exec_done, core_reset;
  logic          prog_last, irq;
  logic [NS*32-1:0] status_data;

  int checks = 0;
  int failures = 0;

  typedef struct {
    logic        wr;
    logic [7:0]  addr;
    logic [31:0] wdata;
    logic [31:0] exp;
  } vec_t;
  vec_t vecs [24];

  multi_core_host_bridge dut (
    .clk(clk), .reset(reset),
    .hps_address(hps_address), .hps_write(hps_write), .hps_read(hps_read),
    .hps_writedata(hps_writedata), .hps_readdata(hps_readdata),
    .hps_readdatavalid(hps_readdatavalid), .hps_waitrequest(hps_waitrequest),
    .prog_data(prog_data), .prog_valid(prog_valid), .prog_ready(prog_ready),
    .prog_last(prog_last), .start_exec(start_exec), .exec_done(exec_done),
    .core_reset(core_reset), .status_data(status_data), .irq(irq)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  task automatic wr(input logic [7:0] a, input logic [31:0] d);
    hps_address = a; hps_writedata = d; hps_write = 1'b1;
    @(negedge clk);
    hps_write = 1'b0;
    $display("wr   addr=0x%02h data=0x%08h", a, d);
  endtask

  task automatic rd_check(input string name, input logic [7:0] a, input logic [31:0] exp);
    hps_address = a; hps_read = 1'b1;
    @(negedge clk);
    hps_read = 1'b0;
    check({name, "_rdv"}, 32'(hps_readdatavalid), 32'd1);
    check(name, hps_readdata, exp);
    $display("rd   addr=0x%02h data=0x%08h expect=0x%08h", a, hps_readdata, exp);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int beats;
    logic [3:0] first_valid;
    logic pat [8];

    reset = 1'b1; hps_address = '0; hps_write = 1'b0; hps_read = 1'b0;
    hps_writedata = '0; prog_ready = '0; exec_done = '0;
    for (int i = 0; i < NS; i++) status_data[i*32 +: 32] = 32'h5000_0000 + 32'(i) * 32'h111;
    pat = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};

    vecs[0]  = '{1'b0, 8'h00, 32'h0, 32'h0};
    vecs[1]  = '{1'b0, 8'h04, 32'h0, 32'h1};
    vecs[2]  = '{1'b0, 8'h0C, 32'h0, 32'h0};
    vecs[3]  = '{1'b0, 8'h10, 32'h0, 32'h0};
    vecs[4]  = '{1'b0, 8'h14, 32'h0, 32'h0};
    vecs[5]  = '{1'b0, 8'h18, 32'h0, 32'h0};
    vecs[6]  = '{1'b1, 8'h00, 32'h208, 32'h0};
    vecs[7]  = '{1'b0, 8'h00, 32'h0, 32'h208};
    vecs[8]  = '{1'b1, 8'h00, 32'hFFFF_F0F4, 32'h0};
    vecs[9]  = '{1'b0, 8'h00, 32'h0, 32'h000};
    vecs[10] = '{1'b1, 8'h18, 32'hFF, 32'h0};
    vecs[11] = '{1'b0, 8'h18, 32'h0, 32'hF};
    vecs[12] = '{1'b1, 8'h18, 32'h0, 32'h0};
    vecs[13] = '{1'b0, 8'h18, 32'h0, 32'h0};
    vecs[14] = '{1'b0, 8'h40, 32'h0, 32'h5000_0000};
    vecs[15] = '{1'b0, 8'h44, 32'h0, 32'h5000_0111};
    vecs[16] = '{1'b0, 8'h7C, 32'h0, 32'h5000_0FFF};
    vecs[17] = '{1'b0, 8'h80, 32'h0, 32'h0};
    vecs[18] = '{1'b0, 8'h08, 32'h0, 32'h0};
    vecs[19] = '{1'b1, 8'h04, 32'hFFFF, 32'h0};
    vecs[20] = '{1'b1, 8'h20, 32'h1234, 32'h0};
    vecs[21] = '{1'b0, 8'h04, 32'h0, 32'h1};
    vecs[22] = '{1'b0, 8'h20, 32'h0, 32'h0};
    vecs[23] = '{1'b0, 8'h42, 32'h0, 32'h0};

    repeat (3) @(negedge clk);
    reset = 1'b0;
    check("rst_readdatavalid", 32'(hps_readdatavalid), 0);
    check("rst_readdata", hps_readdata, 0);
    check("rst_prog_valid", 32'(prog_valid), 0);
    check("rst_prog_last", 32'(prog_last), 0);
    check("rst_prog_data", prog_data, 0);
    check("rst_start_exec", 32'(start_exec), 0);
    check("rst_core_reset", 32'(core_reset), 0);
    check("rst_irq", 32'(irq), 0);
    check("waitrequest", 32'(hps_waitrequest), 0);

    // Register map vectors; vector 8 sets every bit except LOAD/START and
    // CH_SEL=0: only IRQ_EN(=0 here) and CH_SEL are stored.
    for (int i = 0; i < 24; i++) begin
      if (vecs[i].wr) wr(vecs[i].addr, vecs[i].wdata);
      else rd_check($sformatf("vec%0d", i), vecs[i].addr, vecs[i].exp);
    end

    // Five-word load on channel 2 with IRQ_EN.
    for (int i = 0; i < 5; i++) wr(8'h08, 32'hA0 + 32'(i));
    rd_check("a_count", 8'h0C, 5);
    prog_ready = 4'b0100;
    wr(8'h00, 32'h209);
    beats = 0; first_valid = prog_valid;
    for (int c = 0; c < 20 && beats < 5; c++) begin
      if (prog_valid[2] && prog_ready[2]) begin
        check($sformatf("a_data%0d", beats), prog_data, 32'hA0 + 32'(beats));
        check($sformatf("a_last%0d", beats), 32'(prog_last), 32'(beats == 4));
        $display("beat ch2 data=0x%08h last=%0b", prog_data, prog_last);
        beats++;
      end
      @(negedge clk);
    end
    check("a_first_valid", 32'(first_valid), 32'h4);
    check("a_beats", 32'(beats), 5);
    check("a_finish_valid", 32'(prog_valid), 0);
    @(negedge clk);
    check("a_irq", 32'(irq), 1);
    rd_check("a_last_len", 8'h14, 5);
    rd_check("a_event", 8'h10, 32'h1);
    wr(8'h10, 32'h1);
    check("a_irq_clr", 32'(irq), 0);
    prog_ready = '0;

    // Fill to full, overflow, then pop+push at full.
    for (int i = 0; i < 256; i++) wr(8'h08, 32'(i));
    rd_check("b_count_full", 8'h0C, 256);
    rd_check("b_status_full", 8'h04, 32'h2);
    wr(8'h08, 32'hDEAD);
    rd_check("b_event_ovf", 8'h10, 32'h2);
    rd_check("b_count_ovf", 8'h0C, 256);
    wr(8'h00, 32'h001);
    prog_ready = 4'b0001; hps_address = 8'h08; hps_writedata = 32'hBEEF; hps_write = 1'b1;
    @(negedge clk);
    prog_ready = '0; hps_write = 1'b0;
    check("b_head_after_pop", prog_data, 32'd1);
    rd_check("b_count_pp", 8'h0C, 256);
    wr(8'h18, 32'h1);
    wr(8'h18, 32'h0);
    wr(8'h10, 32'hFFFF_FFFF);
    rd_check("b_count_flushed", 8'h0C, 0);

    // Back-pressure on channel 1; a word pushed mid-load stays queued.
    for (int i = 0; i < 3; i++) wr(8'h08, 32'hC0 + 32'(i));
    wr(8'h00, 32'h101);
    beats = 0;
    for (int k = 0; k < 8; k++) begin
      prog_ready = {2'b00, pat[k], 1'b0};
      if (k == 1) begin
        hps_address = 8'h08; hps_writedata = 32'hC3; hps_write = 1'b1;
      end
      if (prog_valid[1]) begin
        check($sformatf("c_data_k%0d", k), prog_data, 32'hC0 + 32'(beats));
        check($sformatf("c_last_k%0d", k), 32'(prog_last), 32'(beats == 2));
        if (pat[k]) begin
          $display("beat ch1 data=0x%08h last=%0b", prog_data, prog_last);
          beats++;
        end
      end
      @(negedge clk);
      hps_write = 1'b0;
    end
    prog_ready = '0;
    check("c_beats", 32'(beats), 3);
    rd_check("c_last_len", 8'h14, 3);
    rd_check("c_count_left", 8'h0C, 1);

    // Reset while streaming discards the queue.
    wr(8'h00, 32'h001);
    check("r_valid_before", 32'(prog_valid), 32'h1);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    check("r_valid_deassert", 32'(prog_valid), 0);
    @(negedge clk);
    check("r_valid_after", 32'(prog_valid), 0);
    rd_check("r_count", 8'h0C, 0);

    // Abort by holding the streaming core in reset after four beats.
    for (int i = 0; i < 10; i++) wr(8'h08, 32'h100 + 32'(i));
    prog_ready = 4'b0010;
    wr(8'h00, 32'h101);
    beats = 0;
    for (int c = 0; c < 30 && beats < 4; c++) begin
      if (prog_valid[1] && prog_ready[1]) begin
        check($sformatf("d_data%0d", beats), prog_data, 32'h100 + 32'(beats));
        beats++;
      end
      @(negedge clk);
    end
    prog_ready = '0;
    wr(8'h18, 32'h2);
    check("d_valid", 32'(prog_valid), 0);
    check("d_core_reset", 32'(core_reset), 32'h2);
    rd_check("d_event_abort", 8'h10, 32'h8);
    rd_check("d_count", 8'h0C, 0);
    rd_check("d_status_idle", 8'h04, 32'h1);
    wr(8'h18, 32'h0);
    wr(8'h10, 32'hFFFF_FFFF);

    // Start pulses, done tracking, invalid channel, set-vs-clear race.
    wr(8'h00, 32'h302);
    check("e_start_pulse", 32'(start_exec), 32'h8);
    @(negedge clk);
    check("e_start_gone", 32'(start_exec), 0);
    exec_done = 4'b1000;
    @(negedge clk);
    rd_check("e_status_done", 8'h04, 32'h801);
    rd_check("e_event_done", 8'h10, 32'h800);
    wr(8'h10, 32'h800);
    rd_check("e_status_clr", 8'h04, 32'h001);
    wr(8'h00, 32'h502);
    check("e_bad_start", 32'(start_exec), 0);
    rd_check("e_event_cmderr", 8'h10, 32'h4);
    exec_done = '0;
    @(negedge clk);
    exec_done = 4'b1000;
    wr(8'h10, 32'h800);
    rd_check("e_set_wins", 8'h10, 32'h804);
    wr(8'h00, 32'h302);
    check("e_start_again", 32'(start_exec), 32'h8);
    rd_check("e_start_clears_done", 8'h10, 32'h4);

    // Simultaneous read and write of CONTROL returns the old value.
    hps_address = 8'h00; hps_writedata = 32'h008; hps_write = 1'b1; hps_read = 1'b1;
    @(negedge clk);
    hps_write = 1'b0; hps_read = 1'b0;
    check("f_rw_old", hps_readdata, 32'h300);
    check("f_irq", 32'(irq), 1);
    rd_check("f_rw_new", 8'h00, 32'h008);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/multi_core_host_bridge.md
MULTI_CORE_HOST_BRIDGE -- requirements
Module: multi_core_host_bridge

Interface
REQ-001 Parameters SHALL be DATA_W=32 (word width), NUM_CH=4 (cores, 1..8), BUF_DEPTH=256 (program FIFO words, power of 2), NUM_STATUS=16 (mirrored status words).
REQ-002 clk  in  1  single clock; all logic SHALL be clocked on its rising edge.
REQ-003 reset  in  1  synchronous, active-high reset.
REQ-004 hps_address  in  8  byte address; hps_write/hps_read  in  1  single-cycle strobes.
REQ-005 hps_writedata  in  DATA_W  write data; hps_readdata  out  DATA_W  registered read data.
REQ-006 hps_readdatavalid  out  1  high exactly one cycle after each hps_read; hps_waitrequest  out  1  tied 0.
REQ-007 prog_data  out  DATA_W  FIFO head; prog_valid  out  NUM_CH  one-hot per core; prog_ready  in  NUM_CH; prog_last  out  1  final word of a load.
REQ-008 start_exec  out  NUM_CH  one-cycle start pulses; exec_done  in  NUM_CH  level from cores; core_reset  out  NUM_CH  level.
REQ-009 status_data  in  NUM_STATUS*DATA_W  flattened core status; irq  out  1  level interrupt.

Function
REQ-010 Register map SHALL be: 0x00 CONTROL, 0x04 STATUS(RO), 0x08 PROG_DATA(WO), 0x0C FIFO_COUNT(RO), 0x10 EVENT(W1C), 0x14 LAST_LEN(RO), 0x18 CORE_RESET(RW); 0x40+4*i status_data word i; other addresses read 0, writes ignored.
REQ-011 CONTROL SHALL hold [3] IRQ_EN and [10:8] CH_SEL as stored bits; [0] LOAD and [1] START are write-1 commands, never stored, read 0.
REQ-012 STATUS SHALL be [0] fifo_empty, [1] fifo_full, [2] busy (FSM not IDLE), [15:8] done[NUM_CH-1:0] zero-extended; EVENT SHALL be [0] load_done, [1] overflow, [2] cmd_error, [3] abort, [15:8] done.
REQ-013 A PROG_DATA write SHALL push into the FIFO; when full and no pop that cycle it SHALL be dropped and set overflow; push and pop in the same cycle at full SHALL both succeed, count unchanged.
REQ-014 LOAD with FSM in IDLE, FIFO non-empty, CH_SEL<NUM_CH SHALL latch channel and remaining=FIFO_COUNT, enter STREAM next cycle.
REQ-015 LOAD with FIFO empty SHALL be ignored; LOAD while busy or CH_SEL>=NUM_CH SHALL be ignored and set cmd_error.
REQ-016 STREAM: prog_valid[ch]=1, prog_data=FIFO head; on prog_valid&prog_ready pop and decrement remaining; prog_last=1 while remaining==1; data SHALL hold stable while ready low.
REQ-017 Words pushed during STREAM SHALL remain queued, not transferred in the current load.
REQ-018 After last word accepted the FSM SHALL enter FINISH for one cycle: LAST_LEN=latched length, set load_done, prog_valid=0, then IDLE.
REQ-019 START with CH_SEL<NUM_CH SHALL pulse start_exec[CH_SEL] next cycle and clear done[CH_SEL]; invalid CH_SEL sets cmd_error only.
REQ-020 A 0->1 edge on exec_done[i] SHALL set done[i] sticky; W1C on EVENT clears; a set and clear in the same cycle SHALL leave the bit set.
REQ-021 core_reset SHALL equal CORE_RESET[NUM_CH-1:0]; asserting the streaming channel's bit SHALL abort: FSM->IDLE next cycle, FIFO flushed, abort set, prog_valid=0.
REQ-022 irq SHALL be IRQ_EN & (|EVENT bits), registered, asserted one cycle after the causing event.
REQ-023 Simultaneous hps_write and hps_read SHALL both be serviced; read returns pre-write value.

Reset
REQ-024 On reset all registers, FIFO pointers, done/event flags SHALL clear, FSM IDLE; outputs: hps_readdata=0, hps_readdatavalid=0, prog_valid=0, prog_last=0, prog_data=0, start_exec=0, core_reset=0, irq=0.
REQ-025 Reset mid-STREAM SHALL discard FIFO contents; no prog_valid in the cycle after reset deasserts.

Structure
REQ-026 Package mhb_pkg SHALL hold register offsets, CONTROL/STATUS/EVENT bit indices, and the FSM state enum (IDLE, STREAM, FINISH).
REQ-027 The FIFO SHALL be sub-module mhb_prog_fifo (push, pop, flush, count, full, empty; head valid combinationally).

Verification
REQ-028 Push 5 words 0xA0..0xA4, CH_SEL=2, LOAD, prog_ready[2]=1 -> prog_valid=0b0100, 5 beats in order, prog_last on 0xA4, LAST_LEN=5, load_done, irq if IRQ_EN.
REQ-029 Fill 256 words, push 0xDEAD -> dropped, overflow=1, FIFO_COUNT=256; pop+push same cycle -> count stays 256.
REQ-030 Load 3 words, toggle prog_ready 1-0-1-0-1 -> exactly 3 transfers, prog_data stable during stalls.
REQ-031 Streaming 10 words on ch1, set CORE_RESET=0x2 after 4 beats -> abort=1, FIFO_COUNT=0, FSM IDLE, core_reset=0x2.
REQ-032 START CH_SEL=3 -> start_exec=0b1000 one cycle; exec_done[3] rises -> done[3]=1, STATUS[11]=1; W1C 0x800 -> cleared; CH_SEL=5 START -> cmd_error only.
